// File: rtl/queue_pkg.sv
// ----------------------------------------------------------------------------
// queue_pkg
//  Shared widths and the writer FSM state type for the clk_10khz byte queue.
//  DATA_W  : queue byte width
//  Q_DEPTH : queue capacity (q_len == Q_DEPTH means full)
//  LEN_W   : width of the queue occupancy bus (holds 0..Q_DEPTH)
// ----------------------------------------------------------------------------
package queue_pkg;
   localparam int DATA_W  = 8;
   localparam int Q_DEPTH = 8;
   localparam int LEN_W   = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ENQ      = 2'd1,
      WAIT_ACK = 2'd2,
      BACKOFF  = 2'd3
   } qw_state_t;
endpackage

// File: rtl/sync_ff.sv
// ----------------------------------------------------------------------------
// sync_ff
//  STAGES-flop synchronizer for a single asynchronous level (a request toggle).
//  clk_10khz : destination clock
//  reset     : asynchronous, active-high; clears every stage
//  d_i       : asynchronous input
//  q_o       : synchronized output (last stage)
// ----------------------------------------------------------------------------
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk_10khz,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);
   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_10khz or posedge reset) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/queue_writer.sv
// ----------------------------------------------------------------------------
// queue_writer
//  Takes bytes from a producer in another clock domain (toggle handshake) and
//  pushes them into the 8-deep byte queue with single-cycle enqueue strobes.
//  Retries while the queue rejects, dropping (and counting) the byte once the
//  retry budget is spent.
//  clk_10khz   : queue-domain clock
//  reset       : asynchronous, active-high
//  src_data    : producer byte, stable while a request is outstanding
//  src_req_tgl : producer request toggle (asynchronous)
//  src_ack_tgl : completion toggle back to producer (accepted or dropped)
//  q_data      : byte presented to the queue
//  q_enqueue   : one-cycle enqueue strobe
//  q_ack       : queue's registered ack, high the cycle after acceptance
//  q_len       : queue occupancy
//  busy        : high whenever the FSM is not idle
//  drop_pulse  : one-cycle pulse per dropped byte
//  drop_cnt    : saturating dropped-byte count
// ----------------------------------------------------------------------------
module queue_writer #(
   parameter int          SYNC_STAGES = 2,
   parameter int          Q_DEPTH     = queue_pkg::Q_DEPTH,
   parameter int          RETRY_GAP   = 4,
   parameter int unsigned MAX_RETRIES = 15
) (
   input  logic                          clk_10khz,
   input  logic                          reset,
   input  logic [queue_pkg::DATA_W-1:0]  src_data,
   input  logic                          src_req_tgl,
   output logic                          src_ack_tgl,
   output logic [queue_pkg::DATA_W-1:0]  q_data,
   output logic                          q_enqueue,
   input  logic                          q_ack,
   input  logic [queue_pkg::LEN_W-1:0]   q_len,
   output logic                          busy,
   output logic                          drop_pulse,
   output logic [7:0]                    drop_cnt
);
   import queue_pkg::*;

   localparam int RW = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);
   localparam int GW = (RETRY_GAP < 2) ? 1 : $clog2(RETRY_GAP + 1);

   qw_state_t         state_q, state_d;
   logic              req_sync, pending;
   logic              req_seen_q, req_seen_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              ack_tgl_q, ack_tgl_d;
   logic              enq_q, enq_d;
   logic              busy_q, busy_d;
   logic              drop_q, drop_d;
   logic [7:0]        drop_cnt_q, drop_cnt_d;
   logic [RW-1:0]     retry_q, retry_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic [RW:0]       retry_inc;
   logic              has_room;

   sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk_10khz (clk_10khz),
      .reset     (reset),
      .d_i       (src_req_tgl),
      .q_o       (req_sync)
   );

   // A request is outstanding while the synchronized toggle differs from
   // the last value we consumed.
   assign pending   = req_sync ^ req_seen_q;
   // Occupancy only pre-filters attempts; the queue's ack has the final say.
   assign has_room  = (q_len < LEN_W'(Q_DEPTH));
   assign retry_inc = {1'b0, retry_q} + (RW+1)'(1);

   always_comb begin
      state_d    = state_q;
      req_seen_d = req_seen_q;
      data_d     = data_q;
      ack_tgl_d  = ack_tgl_q;
      enq_d      = 1'b0;
      drop_d     = 1'b0;
      drop_cnt_d = drop_cnt_q;
      retry_d    = retry_q;
      gap_d      = gap_q;
      unique case (state_q)
         IDLE: begin
            if (pending) begin
               data_d     = src_data;
               req_seen_d = req_sync;
               retry_d    = '0;
               if (has_room) begin
                  state_d = ENQ;
                  enq_d   = 1'b1;
               end else begin
                  state_d = BACKOFF;
                  gap_d   = GW'(RETRY_GAP);
               end
            end
         end
         ENQ: state_d = WAIT_ACK;
         WAIT_ACK: begin
            if (q_ack) begin
               ack_tgl_d = ~ack_tgl_q;
               state_d   = IDLE;
            end else if (MAX_RETRIES != 0 && retry_inc == (RW+1)'(MAX_RETRIES)) begin
               drop_d     = 1'b1;
               drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;
               ack_tgl_d  = ~ack_tgl_q;
               state_d    = IDLE;
            end else begin
               retry_d = retry_inc[RW-1:0];
               gap_d   = GW'(RETRY_GAP);
               state_d = BACKOFF;
            end
         end
         BACKOFF: begin
            if (gap_q <= GW'(1)) begin
               // Gap expired: try again, or wait another gap without
               // charging a retry if the queue is still full.
               if (has_room) begin
                  gap_d   = '0;
                  enq_d   = 1'b1;
                  state_d = ENQ;
               end else begin
                  gap_d = GW'(RETRY_GAP);
               end
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_10khz or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         req_seen_q <= 1'b0;
         data_q     <= '0;
         ack_tgl_q  <= 1'b0;
         enq_q      <= 1'b0;
         busy_q     <= 1'b0;
         drop_q     <= 1'b0;
         drop_cnt_q <= '0;
         retry_q    <= '0;
         gap_q      <= '0;
      end else begin
         state_q    <= state_d;
         req_seen_q <= req_seen_d;
         data_q     <= data_d;
         ack_tgl_q  <= ack_tgl_d;
         enq_q      <= enq_d;
         busy_q     <= busy_d;
         drop_q     <= drop_d;
         drop_cnt_q <= drop_cnt_d;
         retry_q    <= retry_d;
         gap_q      <= gap_d;
      end
   end

   assign src_ack_tgl = ack_tgl_q;
   assign q_data      = data_q;
   assign q_enqueue   = enq_q;
   assign busy        = busy_q;
   assign drop_pulse  = drop_q;
   assign drop_cnt    = drop_cnt_q;
endmodule
